csi2_hdr_req_buffer: RTL
========================

Name: csi2_hdr_req_buffer

Overview:
- Per-input-channel packet-header queue on the requester side of the CSI-2 4-to-1 aggregation arbiter.
- Stores packet headers decoded by the CSI-2 receive parser and presents the head header to the arbiter as hdr_req / wdcnt / dtype / chID / SPtype.
- Completes the grant handshake, paces line-buffer reads for long-packet payloads, and pulses xfrdone when each packet finishes.
- One instance per arbiter input port (hdr0, hdr1, ...).

Parameters:
- DEPTH, 4, header FIFO entries; power of 2, minimum 2.
- LANE_BYTES, 4, payload bytes consumed per line-buffer read beat; one of 1, 2, 4.

Ports:
- clk_i  in  1  tx byte clock
- rst_n_i  in  1  asynchronous active-low reset
- hdr_wr_en  in  1  parser writes one header this cycle
- hdr_wdcnt_in  in  16  word count, or short-packet data field
- hdr_dtype_in  in  6  CSI-2 data type
- hdr_chID_in  in  2  virtual channel to emit
- arb_gnt  in  1  grant from arbiter
- arb_lp_start  in  1  arbiter has started the long-packet payload
- c2d_data_rdy  in  1  cmos2dphy accepts a payload beat this cycle
- hdr_req  out  1  request to arbiter
- hdr_wdcnt  out  16  head entry word count
- hdr_dtype  out  6  head entry data type
- hdr_chID  out  2  head entry virtual channel
- hdr_SPtype  out  1  1 = short packet, 0 = long packet
- hdr_rd_lbfr_en  out  1  line-buffer read strobe
- hdr_xfrdone  out  1  one-cycle pulse when the packet completes
- hdr_full  out  1  FIFO holds DEPTH entries
- hdr_empty  out  1  FIFO holds 0 entries
- hdr_ovf  out  1  sticky overflow flag

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - FIFO flushed; pointers and count = 0.
  - State = IDLE; beat counter = 0.
  - All outputs 0 except hdr_empty = 1.
  - Reset mid-transfer abandons the packet with no xfrdone.
- FIFO:
  - Entry = {chID, dtype, wdcnt}, 24 bits.
  - A write when not full pushes at the rising edge.
  - A write when full is dropped and sets hdr_ovf; hdr_ovf clears only on reset.
  - Push and pop in the same cycle: count unchanged. Pop when full plus push is legal and accepted.
  - Pointers wrap modulo DEPTH.
- Head outputs: hdr_wdcnt, hdr_dtype and hdr_chID show the head entry and are stable from REQ through DONE. They are 0 when empty.
- hdr_SPtype = (head dtype[5:4] == 2'b00), i.e. dtypes 0x00–0x0F are short packets.
- Beats = ceil(wdcnt / LANE_BYTES), computed in 17-bit arithmetic so wdcnt = 0xFFFF does not overflow.
- FSM states: IDLE, REQ, WAIT_LP, READ, DONE.
  - IDLE → REQ when the FIFO is not empty. Push at edge E0 gives hdr_req = 1 from edge E1.
  - REQ: hdr_req = 1.
    - arb_gnt = 1 and short packet → DONE.
    - arb_gnt = 1 and long packet → WAIT_LP.
  - WAIT_LP: on arb_lp_start, load the beat counter.
    - Beats = 0 → DONE.
    - Otherwise → READ.
  - READ: hdr_rd_lbfr_en = c2d_data_rdy (combinational).
    - The counter decrements on each enabled beat.
    - The beat that takes the counter to 0 moves to DONE.
    - No beats are issued while c2d_data_rdy is low.
  - DONE (one cycle): hdr_xfrdone = 1, pop head → IDLE.
  - Back-to-back packets: IDLE lasts one cycle, so hdr_req re-asserts 2 cycles after the xfrdone pulse.
- hdr_req, hdr_xfrdone, hdr_full, hdr_empty and hdr_ovf are decoded from registers only (glitch-free).
- arb_gnt outside REQ and arb_lp_start outside WAIT_LP are ignored.
- A grant held high for several cycles is consumed once.

Test Plan:
- Short packet: write dtype 0x00, wdcnt 0x0001, chID 1; grant at the first hdr_req.
  - Expect hdr_SPtype = 1, no rd_lbfr_en, xfrdone pulse 1 cycle after the grant, hdr_empty = 1 afterwards.
- Long packet, LANE_BYTES = 4: write dtype 0x2B, wdcnt 10; grant, then lp_start, c2d_data_rdy high.
  - Expect exactly 3 rd_lbfr_en beats, then an xfrdone pulse.
- Backpressure: same packet with c2d_data_rdy toggling 1,0,0,1,1.
  - Expect beats only on high cycles, 3 in total, and xfrdone after the 3rd.
- Overflow: 5 writes with no grant at DEPTH = 4.
  - Expect hdr_full = 1, hdr_ovf = 1, 5th header lost, 4 headers drained in write order.
- Simultaneous push/pop: write in the DONE cycle while full.
  - Expect count to stay at 4, no overflow, hdr_ovf = 0.
- Edge cases:
  - Long packet with wdcnt 0 → xfrdone with no beats.
  - wdcnt 0xFFFF → 16384 beats.
  - Reset asserted in READ → all outputs cleared immediately, no xfrdone.

Source files
------------

// File: rtl/csi2_hdr_req_buffer_if.sv
// csi2_hdr_req_buffer_if: parser-write, arbiter-handshake and line-buffer pacing signals of one header request buffer.
interface csi2_hdr_req_buffer_if;
    logic        hdr_wr_en;
    logic [15:0] hdr_wdcnt_in;
    logic [5:0]  hdr_dtype_in;
    logic [1:0]  hdr_chID_in;
    logic        arb_gnt;
    logic        arb_lp_start;
    logic        c2d_data_rdy;
    logic        hdr_req;
    logic [15:0] hdr_wdcnt;
    logic [5:0]  hdr_dtype;
    logic [1:0]  hdr_chID;
    logic        hdr_SPtype;
    logic        hdr_rd_lbfr_en;
    logic        hdr_xfrdone;
    logic        hdr_full;
    logic        hdr_empty;
    logic        hdr_ovf;
    modport master (
        output hdr_wr_en, hdr_wdcnt_in, hdr_dtype_in, hdr_chID_in, arb_gnt, arb_lp_start, c2d_data_rdy,
        input  hdr_req, hdr_wdcnt, hdr_dtype, hdr_chID, hdr_SPtype, hdr_rd_lbfr_en, hdr_xfrdone,
               hdr_full, hdr_empty, hdr_ovf
    );
    modport slave (
        input  hdr_wr_en, hdr_wdcnt_in, hdr_dtype_in, hdr_chID_in, arb_gnt, arb_lp_start, c2d_data_rdy,
        output hdr_req, hdr_wdcnt, hdr_dtype, hdr_chID, hdr_SPtype, hdr_rd_lbfr_en, hdr_xfrdone,
               hdr_full, hdr_empty, hdr_ovf
    );
endinterface

// File: rtl/csi2_hdr_req_buffer.sv
// csi2_hdr_req_buffer: per-channel CSI-2 header FIFO that requests the arbiter, paces payload reads and flags completion.
module csi2_hdr_req_buffer #(
    parameter int DEPTH      = 4,
    parameter int LANE_BYTES = 4
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    csi2_hdr_req_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LB_SH = $clog2(LANE_BYTES);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_LP, READ, DONE} state_t;
    state_t        state_q, state_d;
    logic [23:0]   mem_q [DEPTH];
    logic [23:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [16:0]   beat_q, beat_d;
    logic [23:0]   head;
    logic [16:0]   beats;
    logic          full, empty, push, pop, sp, rd_en;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign pop   = state_q == DONE;
    assign push  = bus.hdr_wr_en && (!full || pop);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign sp    = !empty && head[21:20] == 2'b00;
    assign rd_en = state_q == READ && bus.c2d_data_rdy;
    // 17-bit sum keeps wdcnt = 0xFFFF from wrapping before the divide
    assign beats = ({1'b0, head[15:0]} + 17'(LANE_BYTES - 1)) >> LB_SH;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {bus.hdr_chID_in, bus.hdr_dtype_in, bus.hdr_wdcnt_in};
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d    = ovf_q | (bus.hdr_wr_en & full & ~pop);
        beat_d   = (state_q == WAIT_LP && bus.arb_lp_start) ? beats : rd_en ? beat_q - 17'd1 : beat_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = empty ? IDLE : REQ;
            REQ:     if (bus.arb_gnt) state_d = sp ? DONE : WAIT_LP;
            WAIT_LP: if (bus.arb_lp_start) state_d = (beats == '0) ? DONE : READ;
            READ:    if (rd_en && beat_q == 17'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.hdr_req        = state_q == REQ;
        bus.hdr_xfrdone    = state_q == DONE;
        bus.hdr_rd_lbfr_en = rd_en;
        bus.hdr_wdcnt      = head[15:0];
        bus.hdr_dtype      = head[21:16];
        bus.hdr_chID       = head[23:22];
        bus.hdr_SPtype     = sp;
        bus.hdr_full       = full;
        bus.hdr_empty      = empty;
        bus.hdr_ovf        = ovf_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            beat_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            beat_q   <= beat_d;
        end
    end
endmodule
